// File: rtl/br_pkg.sv
// Shared branch definitions: br_type encodings and branch-resolve FSM states.
// Used by branch_resolve_unit, br_cond_eval and the ID-stage decoder.
package br_pkg;

    typedef logic [2:0] br_type_t;

    localparam br_type_t BR_NONE = 3'b000;
    localparam br_type_t BR_BEZ  = 3'b001;
    localparam br_type_t BR_BNE  = 3'b010;
    localparam br_type_t BR_JMP  = 3'b011;
    localparam br_type_t BR_BLTZ = 3'b100;
    localparam br_type_t BR_BGTZ = 3'b101;
    localparam br_type_t BR_BLT  = 3'b110;
    localparam br_type_t BR_BLTU = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational taken/not-taken evaluation for the eight branch modes.
module br_cond_eval
    import br_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  br_type_t          br_type,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] src2_val,
    output logic              taken
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (val1 == '0);
    assign is_neg  = val1[DATA_W-1];

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_NONE: taken = 1'b0;
            BR_BEZ:  taken = is_zero;
            BR_BNE:  taken = (val1 != src2_val);
            BR_JMP:  taken = 1'b1;
            BR_BLTZ: taken = is_neg;
            BR_BGTZ: taken = !is_neg && !is_zero;
            BR_BLT:  taken = ($signed(val1) < $signed(src2_val));
            BR_BLTU: taken = (val1 < src2_val);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered EX-stage branch resolver with target adder and counted flush window.
// Optional statistics counters are enabled by defining BR_STATS_EN.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FLUSH_DEPTH = 2
`ifdef BR_STATS_EN
    ,
    parameter int STAT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: a descriptor transfers on a rising edge where in_valid and
    // in_ready are both high; in_valid while in_ready is low is dropped.
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        br_type,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] src2_val,
    input  logic [DATA_W-1:0] pc_next,
    input  logic [DATA_W-1:0] offset,
    output logic              br_valid,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
`ifdef BR_STATS_EN
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_taken,
`endif
    output logic              flush
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

    logic [0:0] state;
    logic [3:0] cnt;
    logic       taken;
    logic       accept;

    br_cond_eval #(.DATA_W(DATA_W)) u_cond (
        .br_type  (br_type_t'(br_type)),
        .val1     (val1),
        .src2_val (src2_val),
        .taken    (taken)
    );

    // Gated by rst so nothing is accepted while reset is held.
    assign in_ready = rst && (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign flush    = (state == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            br_valid  <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= '0;
        end else begin
            br_valid <= accept;
            if (accept) begin
                br_taken  <= taken;
                br_target <= pc_next + (offset << 2);
            end
            case (state)
                ST_IDLE: begin
                    if (accept && taken) begin
                        state <= ST_FLUSH;
                        cnt   <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (cnt != 4'd0) cnt   <= cnt - 4'd1;
                    else             state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BR_STATS_EN
    // Saturating counters; NONE descriptors are not counted as branches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_branches <= '0;
            stat_taken    <= '0;
        end else if (accept && (br_type_t'(br_type) != BR_NONE)) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
            if (taken && (stat_taken != '1)) stat_taken <= stat_taken + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed steps plus random traffic
// against a cycle-level reference model and an expected-result queue.
module tb_branch_resolve_unit;

    localparam int DW = 32;
    localparam int FD = 2;
    localparam int SW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    br_type;
    logic [DW-1:0] val1;
    logic [DW-1:0] src2_val;
    logic [DW-1:0] pc_next;
    logic [DW-1:0] offset;
    logic          br_valid;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic          flush;
`ifdef BR_STATS_EN
    logic [SW-1:0] stat_branches;
    logic [SW-1:0] stat_taken;
`endif

    branch_resolve_unit #(
        .DATA_W      (DW),
        .FLUSH_DEPTH (FD)
`ifdef BR_STATS_EN
        ,
        .STAT_W      (SW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .br_type   (br_type),
        .val1      (val1),
        .src2_val  (src2_val),
        .pc_next   (pc_next),
        .offset    (offset),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_target (br_target),
`ifdef BR_STATS_EN
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken),
`endif
        .flush     (flush)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    int            checks   = 0;
    int            failures = 0;
    logic [DW:0]   exp_q[$];
    int            flush_left = 0;
    logic          held_taken = 1'b0;
    logic [DW-1:0] held_tgt   = '0;
    int            m_branches = 0;
    int            m_taken    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic longint as_signed(input logic [DW-1:0] x);
        longint u;
        u = longint'(x);
        return x[DW-1] ? (u - 64'sh1_0000_0000) : u;
    endfunction

    function automatic logic ref_taken(input logic [2:0] t, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
        longint ua, ub, sa, sb;
        ua = longint'(a);
        ub = longint'(b);
        sa = as_signed(a);
        sb = as_signed(b);
        case (t)
            3'd0:    return 1'b0;
            3'd1:    return ua == 0;
            3'd2:    return ua != ub;
            3'd3:    return 1'b1;
            3'd4:    return sa < 0;
            3'd5:    return sa > 0;
            3'd6:    return sa < sb;
            default: return ua < ub;
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_target(input logic [DW-1:0] pc, input logic [DW-1:0] off);
        longint sum;
        sum = (longint'(pc) + 4 * longint'(off)) % 64'sh1_0000_0000;
        return sum[DW-1:0];
    endfunction

    // driver: one clock cycle of stimulus plus all per-cycle checks
    task automatic cyc(input logic r, input logic v, input logic [2:0] t,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] pc, input logic [DW-1:0] off, input string tag);
        logic          exp_ready;
        logic          acc;
        logic          tk;
        logic [DW-1:0] tg;
        logic [DW:0]   ent;
        rst = r; in_valid = v; br_type = t;
        val1 = a; src2_val = b; pc_next = pc; offset = off;
        tk = 1'b0;
        tg = '0;
        #1;
        exp_ready = r && (flush_left == 0);
        chk($sformatf("%s.in_ready", tag), 64'(in_ready), 64'(exp_ready));
        acc = v && exp_ready;
        if (acc) begin
            tk = ref_taken(t, a, b);
            tg = ref_target(pc, off);
            exp_q.push_back({tk, tg});
        end
        @(posedge clk);
        #1;
        if (!r) begin
            flush_left = 0;
            held_taken = 1'b0;
            held_tgt   = '0;
            m_branches = 0;
            m_taken    = 0;
            exp_q.delete();
        end else if (acc) begin
            held_taken = tk;
            held_tgt   = tg;
            flush_left = tk ? FD : 0;
            if (t != 3'd0) begin
                if (m_branches < (1 << SW) - 1) m_branches++;
                if (tk && m_taken < (1 << SW) - 1) m_taken++;
            end
        end else if (flush_left > 0) begin
            flush_left--;
        end
        chk($sformatf("%s.br_valid", tag), 64'(br_valid), 64'(acc));
        if (acc) begin
            ent = exp_q.pop_front();
            chk($sformatf("%s.br_taken", tag), 64'(br_taken), 64'(ent[DW]));
            chk($sformatf("%s.br_target", tag), 64'(br_target), 64'(ent[DW-1:0]));
        end else begin
            chk($sformatf("%s.taken_hold", tag), 64'(br_taken), 64'(held_taken));
            chk($sformatf("%s.target_hold", tag), 64'(br_target), 64'(held_tgt));
        end
        chk($sformatf("%s.flush", tag), 64'(flush), 64'(flush_left > 0));
`ifdef BR_STATS_EN
        chk($sformatf("%s.stat_branches", tag), 64'(stat_branches), 64'(m_branches));
        chk($sformatf("%s.stat_taken", tag), 64'(stat_taken), 64'(m_taken));
`endif
    endtask

    task automatic idle(input string tag);
        cyc(1'b1, 1'b0, 3'd0, '0, '0, '0, '0, tag);
    endtask

    initial begin
        logic [DW-1:0] a, b;
        rst = 1'b0; in_valid = 1'b0; br_type = '0;
        val1 = '0; src2_val = '0; pc_next = '0; offset = '0;

        // reset
        cyc(1'b0, 1'b0, 3'd0, '0, '0, '0, '0, "reset0");
        cyc(1'b0, 1'b1, 3'd3, '0, '0, '0, '0, "reset1");

        // BEZ taken, flush window of FD cycles
        cyc(1'b1, 1'b1, 3'd1, 32'h0, 32'h5, 32'h100, 32'h3, "bez");
        chk("bez.target_const", 64'(br_target), 64'h10C);
        chk("bez.taken_const", 64'(br_taken), 64'h1);
        idle("bez_fl1");
        idle("bez_fl2");
        idle("bez_after");

        // signed vs unsigned less-than
        cyc(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h0, "blt");
        chk("blt.taken_const", 64'(br_taken), 64'h1);
        idle("blt_fl1");
        idle("blt_fl2");
        cyc(1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h0, "bltu");
        chk("bltu.taken_const", 64'(br_taken), 64'h0);

        // back-to-back not-taken
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 3'd2, 32'h1234 + i, 32'h1234 + i, 32'h400 + 4 * i, i, "bne_b2b");
        idle("bne_after");

        // JMP with in_valid held through flush: squashed descriptors vanish
        cyc(1'b1, 1'b1, 3'd3, '0, '0, 32'h800, 32'hFFFF_FFFE, "jmp");
        chk("jmp.target_const", 64'(br_target), 64'h7F8);
        cyc(1'b1, 1'b1, 3'd2, 32'h1, 32'h2, 32'h900, 32'h1, "squash1");
        cyc(1'b1, 1'b1, 3'd2, 32'h1, 32'h2, 32'h900, 32'h1, "squash2");
        cyc(1'b1, 1'b1, 3'd1, 32'h7, 32'h0, 32'hA00, 32'h2, "post_squash");

        // reset in the first flush cycle
        cyc(1'b1, 1'b1, 3'd3, '0, '0, 32'hB00, 32'h10, "jmp2");
        cyc(1'b0, 1'b0, 3'd0, '0, '0, '0, '0, "mid_flush_rst");
        chk("mid_flush_rst.target_const", 64'(br_target), 64'h0);
        cyc(1'b0, 1'b0, 3'd0, '0, '0, '0, '0, "rst_hold");
        cyc(1'b1, 1'b1, 3'd4, 32'h8000_0000, '0, 32'hC00, 32'h1, "bltz_after_rst");

        // target wrap on NONE
        idle("pre_wrap1");
        idle("pre_wrap2");
        cyc(1'b1, 1'b1, 3'd0, '0, '0, 32'hFFFF_FFFC, 32'h1, "none_wrap");
        chk("none_wrap.target_const", 64'(br_target), 64'h0);
        cyc(1'b1, 1'b1, 3'd5, 32'h1, '0, 32'h10, 32'h0, "bgtz");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            b = $urandom;
            case ($urandom_range(0, 3))
                0:       a = b;
                1:       a = '0;
                2:       a = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h1;
                default: a = $urandom;
            endcase
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)), a, b, $urandom, $urandom, "rand");
        end

        chk("exp_q.empty", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational EX-stage branch condition check in the MIPS pipeline.
- Accepts one branch descriptor per cycle from ID/EX under a valid/ready handshake.
- Resolves taken/not-taken over 8 branch modes (signed and unsigned) and computes the branch target.
- Drives a counted flush window that squashes wrong-path issues after a taken branch; sits between the ID/EX register and the IF-stage PC mux.

Parameters:
DATA_W, 32, operand, PC and target width
FLUSH_DEPTH, 2, cycles flush stays high after a taken branch; legal range 1..15
STAT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  branch descriptor present
in_ready  output  1  unit can accept a descriptor this cycle
br_type  input  3  branch mode, encoding below
val1  input  DATA_W  first operand (rs)
src2_val  input  DATA_W  second operand (rt)
pc_next  input  DATA_W  PC of the following instruction (PC+4)
offset  input  DATA_W  sign-extended word offset
br_valid  output  1  one-cycle pulse: a resolution is presented
br_taken  output  1  resolution result, qualified by br_valid
br_target  output  DATA_W  pc_next + (offset << 2), qualified by br_valid
flush  output  1  squash IF/ID while high

Behaviour:
- Reset: on a clk edge with rst=0, state->IDLE; br_valid, br_taken, flush=0; br_target=0; in_ready=0 during reset, 1 in the first cycle after release. Reset overrides everything, including mid-flush.
- br_type encoding:
  - 000: NONE, never taken.
  - 001: BEZ, val1==0.
  - 010: BNE, val1!=src2_val.
  - 011: JMP, always taken.
  - 100: BLTZ, signed val1<0.
  - 101: BGTZ, signed val1>0.
  - 110: BLT, signed val1<src2_val.
  - 111: BLTU, unsigned val1<src2_val.
- Accept: in_valid & in_ready at edge N registers the result. br_valid=1 in cycle N+1 only; br_taken and br_target hold until the next accept (reset clears them).
- Target arithmetic: offset shifted left by 2, added to pc_next modulo 2^DATA_W, wrap-around silent. Computed for every type, including NONE and not-taken.
- FSM states:
  - IDLE: in_ready=1, flush=0.
  - FLUSH: in_ready=0, flush=1, internal counter cnt.
- Transitions:
  - IDLE -> FLUSH on an accept with a taken result; cnt loads FLUSH_DEPTH-1. flush is high in cycles N+1..N+FLUSH_DEPTH.
  - FLUSH with cnt!=0: cnt decrements.
  - FLUSH with cnt==0: -> IDLE; in_ready=1 again in cycle N+FLUSH_DEPTH+1.
- Not-taken accepts keep IDLE, so back-to-back accepts every cycle are legal.
- Squash: in_valid while in_ready=0 is dropped with no br_valid pulse. The upstream stage must not rely on retry; those instructions are wrong-path.
- Operand/type inputs are sampled only on an accept edge.

Optional Feature:
- Macro BR_STATS_EN.
- Defined: adds outputs stat_branches and stat_taken (each STAT_W). On each accept with br_type!=000, stat_branches increments; if taken, stat_taken also increments. Both saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package br_pkg:
  - 3-bit br_type_t and the 8 encoding constants.
  - FSM state constants ST_IDLE and ST_FLUSH.
  - Shared with the ID-stage decoder.
- One natural sub-module: br_cond_eval, a purely combinational evaluation of taken from br_type, val1 and src2_val. The top level holds the registers, FSM, target adder and stats.

Test Plan:
- Reset then BEZ val1=0, pc_next=0x100, offset=3 -> next cycle br_valid=1, br_taken=1, br_target=0x10C; flush high 2 cycles; in_ready low 2 cycles, then high.
- BLT val1=0xFFFFFFFF, src2_val=1 (taken) vs BLTU same operands (not taken) -> br_taken 1 then 0; signed/unsigned split verified.
- Back-to-back not-taken BNE with equal operands, 4 consecutive accepts -> 4 consecutive br_valid pulses, flush never high.
- JMP accepted, in_valid held high through the flush window -> no br_valid during flush; next accept only after in_ready returns.
- rst=0 asserted in the first FLUSH cycle -> next cycle flush=0, br_valid=0, br_target=0, in_ready=0; after release in_ready=1 and the next accept resolves normally.
- pc_next=0xFFFFFFFC, offset=1, type NONE -> br_taken=0, br_target=0x00000000 (wrap); with BR_STATS_EN, stat_branches unchanged.
